// File: rtl/theta_ramp.sv
// Angle ramp generator: walks o_theta one degree at a time toward a clamped target,
// with one step every STEP_DIV cycles, a hold input and a one-cycle update strobe.
module theta_ramp #(
  parameter int STEP_DIV   = 50000,
  parameter int THETA_MIN  = 0,
  parameter int THETA_MAX  = 180,
  parameter int THETA_INIT = 90
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [7:0] i_theta_target,
  input  logic       i_load,
  input  logic       i_hold,
  output logic [7:0] o_theta,
  output logic       o_update,
  output logic       o_busy,
  output logic       o_at_target
);

  typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

  localparam logic [23:0] StepLast  = 24'(STEP_DIV - 1);
  localparam logic [7:0]  ThetaMin  = 8'(THETA_MIN);
  localparam logic [7:0]  ThetaMax  = 8'(THETA_MAX);
  localparam logic [7:0]  ThetaInit = 8'(THETA_INIT);

  state_e      state_q, state_d, state_eval;
  logic [7:0]  target_q, target_d;
  logic [7:0]  theta_q, theta_d;
  logic [23:0] presc_q, presc_d;
  logic        update_q, update_d;
  logic [7:0]  target_clamped;
  int          target_in;

  // Widen to a signed int so the lower bound compare stays meaningful when THETA_MIN is 0.
  always_comb begin
    target_in = int'({24'd0, i_theta_target});
    if (target_in < THETA_MIN) begin
      target_clamped = ThetaMin;
    end else if (target_in > THETA_MAX) begin
      target_clamped = ThetaMax;
    end else begin
      target_clamped = i_theta_target;
    end
  end

  always_comb begin
    if (target_q == theta_q) begin
      state_eval = StIdle;
    end else if (target_q > theta_q) begin
      state_eval = StUp;
    end else begin
      state_eval = StDown;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    theta_d  = theta_q;
    presc_d  = presc_q;
    update_d = 1'b0;

    if (i_load) begin
      target_d = target_clamped;
    end

    if (!i_hold) begin
      state_d = state_eval;
      // A step is only taken when the direction still stands; this keeps a load that
      // lands on o_theta from overshooting and keeps o_theta inside the legal range.
      if (state_eval != state_q || state_q == StIdle) begin
        presc_d = '0;
      end else if (presc_q == StepLast) begin
        presc_d  = '0;
        update_d = 1'b1;
        theta_d  = (state_q == StUp) ? theta_q + 8'd1 : theta_q - 8'd1;
      end else begin
        presc_d = presc_q + 24'd1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= StIdle;
      target_q <= ThetaInit;
      theta_q  <= ThetaInit;
      presc_q  <= '0;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      theta_q  <= theta_d;
      presc_q  <= presc_d;
      update_q <= update_d;
    end
  end

  assign o_theta     = theta_q;
  assign o_update    = update_q;
  assign o_busy      = (state_q != StIdle);
  assign o_at_target = (theta_q == target_q);

endmodule
